// File: rtl/mp_add_scheduler_if.sv
// Bundle of the two requester ports, the response port and the shared adder port.
// The scheduler connects through the slave modport. Requesters, the consumer and the adder use master.
interface mp_add_scheduler_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_sub;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_sub;

    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic [W-1:0] resp_sum;
    logic         resp_cout;
    logic         resp_ovf;

    logic [15:0]  add_a;
    logic [15:0]  add_b;
    logic         add_cin;
    logic         add_p0;
    logic [15:0]  add_sum;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  resp_ready, add_sum,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_sum, resp_cout, resp_ovf,
        output add_a, add_b, add_cin, add_p0
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output resp_ready, add_sum,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_sum, resp_cout, resp_ovf,
        input  add_a, add_b, add_cin, add_p0
    );
endinterface

// File: rtl/mp_add_scheduler.sv
// Multi-precision add/subtract scheduler in front of one shared 16-bit adder.
// It grants one of two requesters round-robin. It then walks the operands through
// the adder one word per cycle, LSW first, with the carry chained in a register.
// It holds the result on a valid/ready response port.
module mp_add_scheduler #(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    mp_add_scheduler_if.slave bus
);
    localparam int            KW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic                   last_r;     // requester granted most recently
    logic                   id_r;
    logic                   carry_r;
    logic                   cout_r;
    logic                   ovf_r;
    logic                   valid_r;
    logic [KW-1:0]          k_r;
    logic [WORDS-1:0][15:0] a_r;
    logic [WORDS-1:0][15:0] b_r;        // already inverted for subtraction
    logic [WORDS-1:0][15:0] sum_r;

    logic                   grant0_s;
    logic                   grant1_s;
    logic                   ready0_s;
    logic                   ready1_s;
    logic [15:0]            word_a_s;
    logic [15:0]            word_b_s;
    logic                   cin_s;
    logic                   cout_s;
    logic                   ovf_s;

    // The adder has no carry output, so rebuild it from the MSBs of its operands and sum.
    function automatic logic carry_from_msb(input logic a15, input logic b15, input logic s15);
        return (a15 & b15) | ((a15 ^ b15) & ~s15);
    endfunction

    // Signed overflow: like-signed operands produced a result of the other sign.
    function automatic logic ovf_from_msb(input logic a15, input logic b15, input logic s15);
        return (a15 == b15) && (s15 != a15);
    endfunction

    // Round-robin arbitration: a tie goes to the requester not granted last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0_s = last_r;
            grant1_s = ~last_r;
        end else begin
            grant0_s = bus.req0_valid;
            grant1_s = bus.req1_valid;
        end
    end

    assign ready0_s       = (state_r == IDLE) && grant0_s && !rst;
    assign ready1_s       = (state_r == IDLE) && grant1_s && !rst;
    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;

    // Present word k and the chained carry to the adder during RUN. Hold the port at zero otherwise.
    always_comb begin
        word_a_s = 16'h0000;
        word_b_s = 16'h0000;
        cin_s    = 1'b0;
        if (state_r == RUN) begin
            word_a_s = a_r[k_r];
            word_b_s = b_r[k_r];
            cin_s    = carry_r;
        end else begin
            word_a_s = 16'h0000;
            word_b_s = 16'h0000;
            cin_s    = 1'b0;
        end
    end

    assign bus.add_a   = word_a_s;
    assign bus.add_b   = word_b_s;
    assign bus.add_cin = cin_s;
    assign bus.add_p0  = 1'b0;

    assign cout_s = carry_from_msb(word_a_s[15], word_b_s[15], bus.add_sum[15]);
    assign ovf_s  = ovf_from_msb(word_a_s[15], word_b_s[15], bus.add_sum[15]);

    assign bus.resp_valid = valid_r;
    assign bus.resp_id    = id_r;
    assign bus.resp_sum   = sum_r;
    assign bus.resp_cout  = cout_r;
    assign bus.resp_ovf   = ovf_r;

    // Control FSM: accept in IDLE, one adder word per RUN cycle, hold the result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            id_r    <= 1'b0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
            k_r     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ready0_s && bus.req0_valid) begin
                        a_r     <= bus.req0_a;
                        b_r     <= bus.req0_sub ? ~bus.req0_b : bus.req0_b;
                        carry_r <= bus.req0_sub;
                        id_r    <= 1'b0;
                        last_r  <= 1'b0;
                        k_r     <= '0;
                        state_r <= RUN;
                    end else if (ready1_s && bus.req1_valid) begin
                        a_r     <= bus.req1_a;
                        b_r     <= bus.req1_sub ? ~bus.req1_b : bus.req1_b;
                        carry_r <= bus.req1_sub;
                        id_r    <= 1'b1;
                        last_r  <= 1'b1;
                        k_r     <= '0;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sum_r[k_r] <= bus.add_sum;
                    carry_r    <= cout_s;
                    if (k_r == K_LAST) begin
                        cout_r  <= cout_s;
                        ovf_r   <= ovf_s;
                        valid_r <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        k_r     <= k_r + 1'b1;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        valid_r <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mp_add_scheduler.sv
// Self-checking bench for mp_add_scheduler.
// The bench provides the shared adder as plain 16-bit arithmetic. A negedge monitor
// follows the expected IDLE/RUN/DONE timeline and checks every handshake, adder word
// and response against a scoreboard filled from whole-width arithmetic.
module tb_mp_add_scheduler;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } resp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    resp_t exp_q[$];

    mp_add_scheduler_if #(.WORDS(WORDS)) bus ();

    mp_add_scheduler #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The shared adder: combinational, 16 bits, carry-out dropped.
    assign bus.add_sum = bus.add_a + bus.add_b + {15'd0, bus.add_cin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [W-1:0] v, input int k);
        return v[16*k +: 16];
    endfunction

    // Reference result computed on the full operand width.
    function automatic resp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub);
        resp_t    r;
        logic [W:0] full;
        r.id = id;
        if (sub) begin
            r.sum  = a - b;
            r.cout = (a >= b);
            r.ovf  = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
        end else begin
            full   = {1'b0, a} + {1'b0, b};
            r.sum  = full[W-1:0];
            r.cout = full[W];
            r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        end
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int           m_state = 0;   // 0 idle, 1 run, 2 done
    int           m_k = 0;
    logic         m_first = 1'b0;
    logic         last_m = 1'b1;
    logic [W-1:0] cur_a, cur_bx;
    logic         cur_sub;
    resp_t        saved, got, want;

    // Cycle-by-cycle expected behaviour, sampled mid-cycle.
    always @(negedge clk) begin
        logic v0, v1, r0, r1, e0, e1, id;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        r0 = bus.req0_ready;
        r1 = bus.req1_ready;
        if (rst) begin
            exp_q.delete();
            last_m  = 1'b1;
            m_state = 0;
            chk("rst_ready0", W'(r0), W'(0));
            chk("rst_ready1", W'(r1), W'(0));
        end else begin
            case (m_state)
                0: begin
                    e0 = v0 && (!v1 || last_m);
                    e1 = v1 && (!v0 || !last_m);
                    chk("idle_ready0", W'(r0), W'(e0));
                    chk("idle_ready1", W'(r1), W'(e1));
                    chk("idle_resp_valid", W'(bus.resp_valid), W'(0));
                    chk("idle_add_a", W'(bus.add_a), W'(0));
                    chk("idle_add_b", W'(bus.add_b), W'(0));
                    chk("idle_add_cin", W'(bus.add_cin), W'(0));
                    chk("add_p0", W'(bus.add_p0), W'(0));
                    if ((v0 && r0) || (v1 && r1)) begin
                        id      = !(v0 && r0);
                        cur_a   = id ? bus.req1_a : bus.req0_a;
                        cur_sub = id ? bus.req1_sub : bus.req0_sub;
                        cur_bx  = id ? bus.req1_b : bus.req0_b;
                        exp_q.push_back(model(id, cur_a, cur_bx, cur_sub));
                        if (cur_sub) cur_bx = ~cur_bx;
                        last_m  = id;
                        m_state = 1;
                        m_k     = 0;
                    end
                end
                1: begin
                    chk("run_ready0", W'(r0), W'(0));
                    chk("run_ready1", W'(r1), W'(0));
                    chk("run_resp_valid", W'(bus.resp_valid), W'(0));
                    chk("run_add_a", W'(bus.add_a), W'(word_of(cur_a, m_k)));
                    chk("run_add_b", W'(bus.add_b), W'(word_of(cur_bx, m_k)));
                    chk("add_p0", W'(bus.add_p0), W'(0));
                    if (m_k == 0) chk("run_add_cin0", W'(bus.add_cin), W'(cur_sub));
                    m_k++;
                    if (m_k == WORDS) begin
                        m_state = 2;
                        m_first = 1'b1;
                    end
                end
                2: begin
                    got = '{id: bus.resp_id, sum: bus.resp_sum, cout: bus.resp_cout, ovf: bus.resp_ovf};
                    chk("done_resp_valid", W'(bus.resp_valid), W'(1));
                    chk("done_ready0", W'(r0), W'(0));
                    chk("done_ready1", W'(r1), W'(0));
                    chk("done_add_a", W'(bus.add_a), W'(0));
                    if (m_first) begin
                        saved = got;
                    end else begin
                        chk("hold_id", W'(got.id), W'(saved.id));
                        chk("hold_sum", got.sum, saved.sum);
                        chk("hold_cout", W'(got.cout), W'(saved.cout));
                        chk("hold_ovf", W'(got.ovf), W'(saved.ovf));
                    end
                    m_first = 1'b0;
                    if (bus.resp_ready) begin
                        chk("resp_expected", W'(exp_q.size() > 0), W'(1));
                        if (exp_q.size() > 0) begin
                            want = exp_q.pop_front();
                            chk("resp_id", W'(got.id), W'(want.id));
                            chk("resp_sum", got.sum, want.sum);
                            chk("resp_cout", W'(got.cout), W'(want.cout));
                            chk("resp_ovf", W'(got.ovf), W'(want.ovf));
                        end
                        m_state = 0;
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    // Call at posedge+1: hold the request until accepted, then drop valid after the accept edge.
    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic ok;
        if (id == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_valid = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((id == 0) ? bus.req0_ready : bus.req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_in_time", W'(ok), W'(1));
        @(posedge clk);
        #1;
        if (id == 0) bus.req0_valid = 1'b0;
        else         bus.req1_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = {W{1'b1}};
            1:       v = {W{1'b0}};
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = {1'b1, {(W-1){1'b0}}};
            default: v = W'({$urandom(), $urandom()});
        endcase
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_resp_sum"}, bus.resp_sum, W'(0));
        chk({tag, "_resp_id"}, W'(bus.resp_id), W'(0));
        chk({tag, "_resp_cout"}, W'(bus.resp_cout), W'(0));
        chk({tag, "_resp_ovf"}, W'(bus.resp_ovf), W'(0));
        chk({tag, "_resp_valid"}, W'(bus.resp_valid), W'(0));
    endtask

    task automatic rand_driver(input int id, input int n);
        repeat (n) begin
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk);
                #1;
            end
            issue(id, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        end
    endtask

    logic rnd_done;
    logic seen;

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        // Both requesters valid from the first cycle after reset: grants must alternate.
        fork
            begin
                issue(0, rand_op(), rand_op(), 1'b0);
                issue(0, rand_op(), rand_op(), 1'b1);
            end
            begin
                issue(1, rand_op(), rand_op(), 1'b1);
                issue(1, rand_op(), rand_op(), 1'b0);
            end
            begin
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join

        // Directed arithmetic vectors.
        issue(0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        issue(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        issue(0, 64'h0, 64'h1, 1'b1);
        issue(0, 64'h5, 64'h3, 1'b1);
        issue(1, 64'h8000_0000_0000_0000, 64'h1, 1'b1);

        // Back-pressure: result parked in DONE for more than 10 cycles while req1 waits.
        repeat (8) @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        issue(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        fork
            issue(1, 64'h2, 64'h3, 1'b1);
            begin
                seen = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (bus.resp_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("bp_resp_valid_seen", W'(seen), W'(1));
                repeat (10) @(negedge clk);
                @(posedge clk);
                #1;
                bus.resp_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;

        // Reset while word k=2 is in the adder: the operation vanishes and the pointer resets.
        issue(0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        chk("midrun_reset_add_a", W'(bus.add_a), W'(0));
        @(posedge clk);
        #1;
        fork
            issue(0, rand_op(), rand_op(), 1'b0);
            issue(1, rand_op(), rand_op(), 1'b0);
        join

        // Randomized traffic with random response back-pressure.
        rnd_done = 1'b0;
        fork
            begin
                fork
                    rand_driver(0, 15);
                    rand_driver(1, 15);
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.resp_ready = 1'($urandom_range(0, 1));
                end
                bus.resp_ready = 1'b1;
            end
        join

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && m_state == 0) break;
        end
        chk("drain_empty", W'(exp_q.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mp_add_scheduler.md
# mp_add_scheduler

Multi-precision add/subtract scheduler that shares one combinational 16-bit parallel-prefix adder between two requesters. It accepts a WORDS×16-bit operation from requester 0 or 1 under round-robin arbitration. It then sequences the operation through the adder one 16-bit word per cycle, least significant word first, chaining the carry in a register. It returns the full result with carry-out and signed overflow on a valid/ready response port. The block sits between the ALU issue logic and the shared adder instance.

## Interface
- WORDS, 4, number of 16-bit words per operation (operand width W = 16*WORDS); legal range 1..8
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  W  operands, requester 0
- req0_sub  in  1  1 = a − b, 0 = a + b
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same meanings for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  requester index of the result
- resp_sum  out  W  result
- resp_cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- resp_ovf  out  1  signed two's-complement overflow
- add_a, add_b  out  16  adder operands
- add_cin  out  1  adder carry-in
- add_p0  out  1  adder group-propagate seed; always 0
- add_sum  in  16  adder result, combinational from add_a/add_b/add_cin

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Arbitrate. One requester valid → it is granted. Both valid → grant the one not granted last. Pointer resets to "last = 1", so req0 wins the first tie.
  - reqN_ready = (state==IDLE) && grantN && !rst, combinational. At most one ready is high.
  - On valid&&ready: latch a, b (b bitwise-inverted if sub), sub, id. Carry register ← sub. Word index k ← 0. Go to RUN.
- RUN, one word per cycle:
  - add_a = a[16k+15:16k], add_b = b'[16k+15:16k], add_cin = carry reg.
  - At clock edge: resp_sum word k ← add_sum; carry reg ← cout_k.
  - cout_k = (add_a[15] & add_b[15]) | ((add_a[15] ^ add_b[15]) & ~add_sum[15]). The adder exposes no carry-out, so it is reconstructed from bit 15.
  - k == WORDS−1: resp_cout ← cout_k; resp_ovf ← (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]); go to DONE. Otherwise k ← k+1.
- DONE: resp_valid = 1. resp_sum, resp_id, resp_cout, resp_ovf are held stable until resp_valid && resp_ready, then go to IDLE. No request is accepted in RUN or DONE.
- add_a, add_b, add_cin = 0 outside RUN; add_p0 = 0 always.
- rst at any time, including mid-RUN or in DONE: state ← IDLE, the in-flight operation is discarded with no response, and the pointer is reset.
- Reset values: resp_valid 0, resp_sum 0, resp_id 0, resp_cout 0, resp_ovf 0, req0_ready 0, req1_ready 0, adder outputs 0.
- Requesters must hold valid and data stable until ready. The block samples them only in the handshake cycle.

## Timing
- Accept handshake in cycle T. RUN occupies T+1 .. T+WORDS (word k in cycle T+1+k). resp_valid rises in cycle T+WORDS+1.
- Response handshake in cycle R → IDLE in R+1. The next accept is possible in R+1.
- Minimum spacing between accepts: WORDS+2 cycles.
- Adder path: single-cycle combinational from add_a/add_b/add_cin to add_sum, registered in this block. There is no pipeline register inside the adder.
- resp_ready held high → a result occupies DONE for exactly one cycle.

## Test plan
- WORDS=4. Accept req0 a=0x0000_0000_0000_FFFF, b=0x1, sub=0 at T → resp_valid at T+5, sum=0x0000_0000_0001_0000, cout=0, ovf=0, id=0.
- req1 a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, sub=0 → sum=0x0, cout=1, ovf=0, id=1. Also a=0x7FFF_FFFF_FFFF_FFFF, b=0x1 → sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- req0 sub: a=0x0, b=0x1 → sum=0xFFFF_FFFF_FFFF_FFFF, cout=0 (borrow). a=0x5, b=0x3 → sum=0x2, cout=1.
- Both valid, continuously, from the first cycle after reset → grants alternate req0, req1, req0. Only one ready is high per cycle, and never in RUN or DONE.
- resp_ready held low for 10 cycles in DONE → resp_valid and all resp fields are stable, no new accept occurs, and reqN_ready stays 0.
- rst asserted in RUN cycle k=2 → the next cycle is IDLE with all outputs at reset values. No response appears, and the next tie grants req0.
